// File: rtl/daq_out_buf.sv
// Store-and-forward DAQ frame buffer. It checks frame structure and holds complete frames in a
// block-RAM FIFO, then replays each committed frame over a valid/ready output.
module daq_out_buf #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic [18:0]      daqp,
  output logic [18:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] wc_err_cnt,
  output logic             buf_empty
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   fcnt_t;
  typedef enum logic [1:0] {StHunt, StBody, StTail, StDiscard} wr_state_e;
  typedef enum logic {RdIdle, RdSend} rd_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [18:0]      in_q;
  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  ptr_t             wr_ptr_q, wr_ptr_d, frame_base_q, frame_base_d;
  ptr_t             committed_ptr_q, committed_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d, rd_ptr_base_q, rd_ptr_base_d, acc_ptr_q, acc_ptr_d;
  logic [10:0]      wcount_q, wcount_d;
  logic [1:0]       tcnt_q, tcnt_d;
  fcnt_t            frames_avail_q, frames_avail_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] wc_err_cnt_q, wc_err_cnt_d;
  logic             buf_empty_q, buf_empty_d;
  logic             ram_vld_q, ram_vld_d;
  logic [19:0]      ram_rdata_q;
  logic [18:0]      dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;

  logic             in_vld, is_hdr, is_trl, is_cnt;
  logic             we, commit, restart, full;
  ptr_t             waddr;
  logic [19:0]      wdata;
  logic             have_data, out_load, accept, last_accept, issue;

  // RAM word: bit 19 tags the count word that closes a committed frame.
  logic [19:0] mem [Depth];

  always_comb begin
    in_vld = ~in_q[18];
    is_hdr = in_vld && (in_q[15:0] == 16'hDB0A);
    is_trl = in_vld && (in_q[15:0] == 16'hDE0D);
    is_cnt = in_vld && (in_q[18:11] == 8'h3A);
  end

  always_comb begin
    wr_state_d      = wr_state_q;
    wr_ptr_d        = wr_ptr_q;
    frame_base_d    = frame_base_q;
    committed_ptr_d = committed_ptr_q;
    wcount_d        = wcount_q;
    tcnt_d          = tcnt_q;
    frame_cnt_d     = frame_cnt_q;
    drop_cnt_d      = drop_cnt_q;
    wc_err_cnt_d    = wc_err_cnt_q;
    we              = 1'b0;
    commit          = 1'b0;
    wdata           = {1'b0, in_q};
    restart         = is_hdr && ((wr_state_q == StBody) || (wr_state_q == StTail));
    // A restarting header overwrites the abandoned frame from its base.
    waddr           = restart ? frame_base_q : wr_ptr_q;
    full            = (ptr_t'(waddr + ptr_t'(1)) == rd_ptr_base_q);
    case (wr_state_q)
      StHunt: begin
        if (is_hdr) begin
          if (full) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            wr_state_d = StDiscard;
          end else begin
            we           = 1'b1;
            frame_base_d = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q + ptr_t'(1);
            wcount_d     = 11'd1;
            wr_state_d   = StBody;
          end
        end
      end
      StBody, StTail: begin
        if (restart) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          if (full) begin
            wr_ptr_d   = frame_base_q;
            wr_state_d = StDiscard;
          end else begin
            we         = 1'b1;
            wr_ptr_d   = frame_base_q + ptr_t'(1);
            wcount_d   = 11'd1;
            wr_state_d = StBody;
          end
        end else if (in_vld) begin
          if (full) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            wr_ptr_d   = frame_base_q;
            // An overflowing count word already closes the frame, so no discard is needed.
            wr_state_d = ((wr_state_q == StTail) && (tcnt_q == 2'd2)) ? StHunt : StDiscard;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            wcount_d = wcount_q + 11'd1;
            if (wr_state_q == StBody) begin
              if (is_trl) begin
                wr_state_d = StTail;
                tcnt_d     = 2'd0;
              end
            end else if (tcnt_q == 2'd2) begin
              commit          = 1'b1;
              wdata[19]       = 1'b1;
              committed_ptr_d = wr_ptr_q + ptr_t'(1);
              frame_cnt_d     = sat_inc(frame_cnt_q);
              if ((wcount_q + 11'd1) != in_q[10:0]) wc_err_cnt_d = sat_inc(wc_err_cnt_q);
              wr_state_d      = StHunt;
            end else begin
              tcnt_d = tcnt_q + 2'd1;
            end
          end
        end
      end
      StDiscard: begin
        if (is_cnt) wr_state_d = StHunt;
      end
      default: wr_state_d = StHunt;
    endcase
  end

  // Read side: RAM data register plus output register form a 2-entry skid.
  always_comb begin
    have_data    = (rd_ptr_q != committed_ptr_q);
    out_load     = !dout_valid_q || dout_ready;
    accept       = dout_valid_q && dout_ready;
    last_accept  = accept && dout_last_q;
    issue        = have_data && ((rd_state_q == RdIdle) || !ram_vld_q || out_load);
    rd_ptr_d     = issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    ram_vld_d    = issue || (ram_vld_q && !out_load);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    if (out_load) begin
      dout_valid_d = ram_vld_q;
      dout_last_d  = ram_vld_q && ram_rdata_q[19];
      if (ram_vld_q) dout_d = ram_rdata_q[18:0];
    end
    acc_ptr_d     = accept ? acc_ptr_q + ptr_t'(1) : acc_ptr_q;
    rd_ptr_base_d = last_accept ? acc_ptr_q + ptr_t'(1) : rd_ptr_base_q;
    frames_avail_d = frames_avail_q;
    if (commit && !last_accept) begin
      frames_avail_d = frames_avail_q + fcnt_t'(1);
    end else if (!commit && last_accept) begin
      frames_avail_d = frames_avail_q - fcnt_t'(1);
    end
    buf_empty_d = (frames_avail_d == '0);
    rd_state_d  = (ram_vld_d || dout_valid_d) ? RdSend : RdIdle;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (issue) ram_rdata_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      in_q            <= 19'h40000;
      wr_state_q      <= StHunt;
      rd_state_q      <= RdIdle;
      wr_ptr_q        <= '0;
      frame_base_q    <= '0;
      committed_ptr_q <= '0;
      rd_ptr_q        <= '0;
      rd_ptr_base_q   <= '0;
      acc_ptr_q       <= '0;
      wcount_q        <= '0;
      tcnt_q          <= '0;
      frames_avail_q  <= '0;
      frame_cnt_q     <= '0;
      drop_cnt_q      <= '0;
      wc_err_cnt_q    <= '0;
      buf_empty_q     <= 1'b1;
      ram_vld_q       <= 1'b0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      dout_last_q     <= 1'b0;
    end else begin
      in_q            <= daqp;
      wr_state_q      <= wr_state_d;
      rd_state_q      <= rd_state_d;
      wr_ptr_q        <= wr_ptr_d;
      frame_base_q    <= frame_base_d;
      committed_ptr_q <= committed_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_ptr_base_q   <= rd_ptr_base_d;
      acc_ptr_q       <= acc_ptr_d;
      wcount_q        <= wcount_d;
      tcnt_q          <= tcnt_d;
      frames_avail_q  <= frames_avail_d;
      frame_cnt_q     <= frame_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      wc_err_cnt_q    <= wc_err_cnt_d;
      buf_empty_q     <= buf_empty_d;
      ram_vld_q       <= ram_vld_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      dout_last_q     <= dout_last_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign wc_err_cnt = wc_err_cnt_q;
  assign buf_empty  = buf_empty_q;

endmodule

// File: tb/tb_daq_out_buf.sv
// Bench for daq_out_buf: directed and randomized frames checked against a frame-level model
// that predicts committed words, counters and overflow drops.
module tb_daq_out_buf;
  localparam int unsigned AW    = 5;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [18:0] IDLE  = 19'h40000;
  localparam logic [18:0] HDR   = 19'h0DB0A;
  localparam logic [18:0] TRL   = 19'h0DE0D;

  logic        clk;
  logic        hard_rst;
  logic [18:0] daqp;
  logic [18:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] wc_err_cnt;
  logic        buf_empty;

  daq_out_buf #(.ADDR_W(AW), .CNT_W(16)) dut (
    .clk        (clk),
    .hard_rst   (hard_rst),
    .daqp       (daqp),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .wc_err_cnt (wc_err_cnt),
    .buf_empty  (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference model.
  logic [19:0] exp_q[$];
  logic [18:0] cur[$];
  int          pend[$];
  int          pend_sum;
  int          trl_idx;
  bit          in_frame, discarding;
  int          exp_frames, exp_drops, exp_wcerr;

  task automatic model_reset();
    exp_q.delete(); cur.delete(); pend.delete();
    pend_sum = 0; trl_idx = -1; in_frame = 0; discarding = 0;
    exp_frames = 0; exp_drops = 0; exp_wcerr = 0;
  endtask

  task automatic model_in(input logic [18:0] w);
    bit hdr, trl, cnt, full, final_w;
    if (w[18]) return;
    hdr = (w[15:0] == 16'hDB0A);
    trl = (w[15:0] == 16'hDE0D);
    cnt = (w[18:11] == 8'h3A);
    if (discarding) begin
      if (cnt) discarding = 0;
      return;
    end
    if (hdr) begin
      full = (pend_sum >= DEPTH - 1);
      if (in_frame || full) exp_drops++;
      cur.delete(); trl_idx = -1;
      in_frame = !full; discarding = full;
      if (!full) cur.push_back(w);
      return;
    end
    if (!in_frame) return;
    final_w = (trl_idx >= 0) && (cur.size() == trl_idx + 3);
    if (pend_sum + cur.size() >= DEPTH - 1) begin
      exp_drops++; cur.delete(); in_frame = 0; discarding = !final_w;
      return;
    end
    cur.push_back(w);
    if (final_w) begin
      exp_frames++;
      if ((cur.size() % 2048) != int'(w[10:0])) exp_wcerr++;
      foreach (cur[i]) exp_q.push_back({i == cur.size() - 1, cur[i]});
      pend.push_back(cur.size());
      pend_sum += cur.size();
      in_frame = 0;
    end else if (trl_idx < 0 && trl) begin
      trl_idx = cur.size() - 1;
    end
  endtask

  // Ready pattern: 0 = held high, 1 = toggling, 2 = random, 3 = held low.
  int rdy_mode = 0;
  bit tgl = 0;
  always @(posedge clk) begin
    #1;
    tgl = !tgl;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = tgl;
      2:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Output monitor: order, content, last flag, and stability while stalled.
  bit          stall_q = 0;
  logic [19:0] prev;
  always @(negedge clk) begin
    logic [19:0] e;
    if (!hard_rst) begin
      stall_q = 0;
    end else begin
      if (stall_q) check("stall_hold", 32'({dout_valid, dout_last, dout}), 32'({1'b1, prev}));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("dout_word", 32'({dout_last, dout}), 32'(e));
          if (e[19] && pend.size() != 0) pend_sum -= pend.pop_front();
        end
      end
      stall_q = dout_valid && !dout_ready;
      prev = {dout_last, dout};
    end
  end

  function automatic logic [18:0] rand_data();
    logic [18:0] w;
    do begin
      w = {1'b0, 18'($urandom)};
    end while (w[15:0] == 16'hDB0A || w[15:0] == 16'hDE0D || w[18:11] == 8'h3A);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [18:0] w);
    daqp = w;
    model_in(w);
    step();
    daqp = IDLE;
  endtask

  task automatic send_frame(input int len, input int cnt, input int gap_pct);
    send(HDR);
    for (int i = 0; i < len - 5; i++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) step();
      send(rand_data());
    end
    send(TRL);
    send(rand_data());
    send(rand_data());
    send({8'h3A, 11'(cnt)});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || dout_valid) && n < 1000) begin
      step();
      n++;
    end
    check("drain_done", 32'(n < 1000), 32'd1);
    step();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
    check({tag, "_wc_err_cnt"}, 32'(wc_err_cnt), 32'(exp_wcerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    hard_rst = 1'b1;
    daqp     = IDLE;
    model_reset();
    #1 hard_rst = 1'b0;
    #2;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_buf_empty", 32'(buf_empty), 32'd1);
    check_counters("rst");
    @(posedge clk);
    #3 hard_rst = 1'b1;
    step();

    // 24-word frame: latency, burst continuity, last flag via monitor.
    send_frame(24, 24, 0);
    step();
    step();
    check("lat_early_valid", 32'(dout_valid), 32'd0);
    step();
    check("lat_valid", 32'(dout_valid), 32'd1);
    check("lat_header", 32'(dout), 32'(HDR));
    for (int i = 0; i < 24; i++) begin
      check("burst_valid", 32'(dout_valid), 32'd1);
      step();
    end
    check("burst_end_valid", 32'(dout_valid), 32'd0);
    drain();
    check_counters("single");
    check("single_buf_empty", 32'(buf_empty), 32'd1);

    // Same frame with a wrong count field.
    send_frame(24, 23, 0);
    drain();
    check_counters("wc_err");

    // Three back-to-back frames with toggling ready.
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      len = int'($urandom_range(5, 10));
      send_frame(len, len, 0);
    end
    drain();
    check_counters("toggle");

    // Random ready, random gaps inside and between frames.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(5, 7));
      send_frame(len, len, 20);
      repeat ($urandom_range(0, 3)) step();
    end
    drain();
    check_counters("random");

    // Overflow with the consumer stalled: second 20-word frame cannot fit.
    rdy_mode = 3;
    send_frame(20, 20, 0);
    send_frame(20, 20, 0);
    repeat (4) step();
    check_counters("ovf");
    check("ovf_buf_empty", 32'(buf_empty), 32'd0);
    rdy_mode = 0;
    drain();
    send_frame(10, 10, 0);
    drain();
    check_counters("ovf_after");

    // Abandoned frame: a header arrives mid-frame.
    send(HDR);
    for (int i = 0; i < 5; i++) send(rand_data());
    send_frame(12, 12, 0);
    drain();
    check_counters("restart");

    // Reset while a frame is streaming out.
    rdy_mode = 3;
    send_frame(20, 20, 0);
    repeat (6) step();
    rdy_mode = 0;
    repeat (4) step();
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #3 hard_rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_last", 32'(dout_last), 32'd0);
    check("mid_rst_buf_empty", 32'(buf_empty), 32'd1);
    model_reset();
    check_counters("mid_rst");
    @(posedge clk);
    #3 hard_rst = 1'b1;
    step();
    send_frame(9, 9, 10);
    drain();
    check_counters("post_rst");
    check("post_rst_buf_empty", 32'(buf_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
